// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs fields and a signed immediate into a 32-bit
// word, rejects illegal/misaligned/out-of-range requests, and buffers words in a 2-entry FIFO.
module instr_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err_valid,
  output logic [1:0]        err_code,
  output logic [15:0]       err_count
);

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_ALIGN = 2'd2;
  localparam logic [1:0] ERR_FMT   = 2'd3;

  localparam logic [1:0]        FULL      = 2'd2;
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [15:0]       CNT_MAX   = 16'hFFFF;

  logic [31:0]       word_c;
  logic [1:0]        code_c;
  logic              range_bad_c;
  logic              reject_c;
  logic              accept_c;
  logic              push_c;
  logic              pop_c;

  logic [31:0]       mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr_q;

  // Bit-scatter the immediate into the selected format.
  always_comb begin
    word_c = '0;
    unique case (in_fmt)
      FMT_I: word_c = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: word_c = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: word_c = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                       in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: word_c = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: word_c = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12],
                       in_rd, in_opcode};
      FMT_R: word_c = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default: word_c = '0;
    endcase
  end

  // Immediate must sign-extend from the top bit the format can hold.
  always_comb begin
    range_bad_c = 1'b0;
    unique case (in_fmt)
      FMT_I, FMT_S: range_bad_c = !((&in_imm[31:11]) || !(|in_imm[31:11]));
      FMT_B:        range_bad_c = !((&in_imm[31:12]) || !(|in_imm[31:12]));
      FMT_J:        range_bad_c = !((&in_imm[31:20]) || !(|in_imm[31:20]));
      FMT_U:        range_bad_c = |in_imm[11:0];
      default:      range_bad_c = 1'b0;
    endcase
  end

  // Error priority: illegal format, then misalignment, then range.
  always_comb begin
    code_c = ERR_NONE;
    if (in_fmt > FMT_R) begin
      code_c = ERR_FMT;
    end else if ((in_fmt == FMT_B || in_fmt == FMT_J) && in_imm[0]) begin
      code_c = ERR_ALIGN;
    end else if (range_bad_c) begin
      code_c = ERR_RANGE;
    end
  end

  assign reject_c  = (code_c != ERR_NONE);
  assign in_ready  = (count != FULL);
  assign out_valid = (count != 2'd0);
  assign out_instr = mem[rd_ptr];
  assign out_addr  = addr_q;

  assign accept_c  = in_valid && in_ready && !flush;
  assign push_c    = accept_c && !reject_c;
  assign pop_c     = out_valid && out_ready && !flush;

  // FIFO storage, pointers, occupancy and head address; flush beats push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      addr_q <= BASE;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      addr_q <= BASE;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= word_c;
        wr_ptr      <= !wr_ptr;
      end
      if (pop_c) begin
        rd_ptr <= !rd_ptr;
        addr_q <= addr_q + ADDR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Rejection reporting: one-cycle pulse, sticky code, saturating count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid <= 1'b0;
      err_code  <= ERR_NONE;
      err_count <= '0;
    end else begin
      err_valid <= accept_c && reject_c;
      if (accept_c && reject_c) begin
        err_code <= code_c;
        if (err_count != CNT_MAX) begin
          err_count <= err_count + 16'd1;
        end
      end
    end
  end

endmodule
